i2c_byte_sequencer: RTL and testbench
=====================================

Name: i2c_byte_sequencer

Overview:
Byte-level command sequencer for the I2C master core. It sits between the control/command registers (cr, txr, rxr, the sr status bits) and the bit-level SCL/SDA controller. It turns one register-level command (START/WRITE/READ/STOP with an ACK choice) into an ordered series of bit commands, shifts data out and in, and returns the byte result, ACK status and a one-cycle done pulse.

Parameters:
CMD_W, 4, width of the bit-command bus. The encoding is one-hot: NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.

Ports:
wb_clk_i  in  1  system clock; all state changes on its rising edge
arst_i  in  1  asynchronous active-low reset
ena  in  1  core enable (ctr[7])
start  in  1  generate START before the byte (cr[7])
stop  in  1  generate STOP after the byte (cr[6])
read  in  1  read a byte (cr[5])
write  in  1  write a byte (cr[4])
ack_in  in  1  ACK value driven after a read: 0=ACK, 1=NACK (cr[3])
din  in  8  byte to transmit (txr)
cmd_ack  out  1  one-cycle command-complete pulse; clears cr bits and sets the IF flag
ack_out  out  1  ACK bit sampled from the slave (RxACK, sr[7])
dout  out  8  received byte (rxr)
busy  out  1  high whenever state is not IDLE (TIP, sr[1])
bit_cmd  out  4  command to the bit controller
bit_din  out  1  SDA value for a WRITE bit command
bit_cmd_ack  in  1  one-cycle pulse: the bit controller finished the current bit command
bit_dout  in  1  SDA value sampled by the last READ bit command
al  in  1  arbitration lost, from the bit controller

Behaviour:
- Reset (arst_i=0, asynchronous):
  - state=IDLE, bit_cmd=NOP, bit_din=0.
  - cmd_ack=0, ack_out=0, busy=0.
  - Shift register sr=0x00, so dout=0x00; bit counter cnt=0.
- All outputs are registered. dout always equals sr.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE accepts a command when ena=1, (start|stop|read|write)=1 and cmd_ack=0. On acceptance:
  - sr<=din and cnt<=7.
  - Next state and bit_cmd are chosen by priority: start→START/START; else read→READ/READ; else write→WRITE/WRITE; else STOP/STOP.
  - bit_cmd becomes valid on the cycle after the command is accepted.
- bit_cmd holds its value until bit_cmd_ack is sampled high. The next command is loaded on that same edge, so there is no forced NOP gap.
- START, on bit_cmd_ack:
  - read=1 → READ.
  - else write=1 → WRITE.
  - else stop=1 → STOP.
  - else → IDLE with cmd_ack pulse.
- WRITE: bit_din=sr[7]. Each bit_cmd_ack shifts sr left by one, filling with 0, and decrements cnt.
- READ: bit_din=1. Each bit_cmd_ack shifts sr left by one, filling with bit_dout, and decrements cnt.
- WRITE/READ when bit_cmd_ack arrives with cnt==0: go to ACK, with no further shift beyond the 8th.
  - From WRITE: bit_cmd=READ, bit_din=1.
  - From READ: bit_cmd=WRITE, bit_din=ack_in.
- ACK, on bit_cmd_ack:
  - ack_out<=bit_dout. This is meaningful after a write; after a read it reflects the bus value.
  - stop=1 → STOP (bit_cmd=STOP); else → IDLE with cmd_ack.
- STOP, on bit_cmd_ack: → IDLE, bit_cmd=NOP, cmd_ack pulse.
- cmd_ack is exactly one cycle wide. The host deasserts its command inputs on the cycle cmd_ack is high, and the cmd_ack=0 acceptance term prevents a re-trigger.
- Abort: al=1, or ena=0 while not IDLE, takes effect at the next edge and has priority over bit_cmd_ack.
  - state=IDLE, bit_cmd=NOP, cnt=0, busy=0.
  - No cmd_ack is generated; sr and ack_out are unchanged.
  - The host sees arbitration loss through AL/IF, handled elsewhere.
- ena=0 in IDLE: commands are ignored.
- Command bits changing mid-operation: only stop, ack_in and read/write (after START) are re-sampled, and only at the decision points above.

Test Plan:
- Write with START: start=1, write=1, din=0xA5.
  - Required: bit_cmd sequence START, WRITE×8 with bit_din 1,0,1,0,0,1,0,1, then READ with bit_din=1.
  - Slave drives bit_dout=0 → ack_out=0, one cmd_ack pulse, busy returns to 0 on the same edge.
- Read with NACK and STOP: read=1, stop=1, ack_in=1; bit_dout stream 0,1,1,0,1,0,0,1.
  - Required: dout=0x69; ACK phase bit_cmd=WRITE with bit_din=1; then STOP; cmd_ack is single-cycle.
- Slave NACK on write: write=1, din=0x00, bit_dout=1 during ACK → ack_out=1, cmd_ack=1, no STOP issued.
- Stop only: stop=1 → exactly one STOP bit command, then cmd_ack; sr unchanged from din load.
- Arbitration loss: al pulse after the 3rd write bit_cmd_ack.
  - Required: next cycle state IDLE, bit_cmd=NOP, busy=0, cmd_ack never asserted.
  - A subsequent start+write is accepted normally.
- Reset mid-read: drop arst_i during READ bit 4.
  - Required: bit_cmd=NOP, busy=0, dout=0x00 and cmd_ack=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/i2c_byte_sequencer_if.sv
// i2c_byte_sequencer_if
//   Groups the signals around the I2C byte sequencer.
//   Host side (control/status registers):
//     ena, start, stop, read, write, ack_in, din  -> into the sequencer
//     cmd_ack, ack_out, dout, busy                <- from the sequencer
//   Bit-controller side (SCL/SDA engine):
//     bit_cmd, bit_din                            -> to the bit controller
//     bit_cmd_ack, bit_dout, al                   <- from the bit controller
//   modport master : the byte sequencer itself
//   modport slave  : everything around it (registers + bit controller)
interface i2c_byte_sequencer_if #(
  parameter int CMD_W = 4
);
  logic             ena;
  logic             start;
  logic             stop;
  logic             read;
  logic             write;
  logic             ack_in;
  logic [7:0]       din;
  logic             cmd_ack;
  logic             ack_out;
  logic [7:0]       dout;
  logic             busy;
  logic [CMD_W-1:0] bit_cmd;
  logic             bit_din;
  logic             bit_cmd_ack;
  logic             bit_dout;
  logic             al;

  modport master (
    input  ena, start, stop, read, write, ack_in, din,
    input  bit_cmd_ack, bit_dout, al,
    output cmd_ack, ack_out, dout, busy, bit_cmd, bit_din
  );

  modport slave (
    output ena, start, stop, read, write, ack_in, din,
    output bit_cmd_ack, bit_dout, al,
    input  cmd_ack, ack_out, dout, busy, bit_cmd, bit_din
  );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer
//   Turns one register-level I2C command (START/WRITE/READ/STOP plus ACK
//   choice) into an ordered series of one-hot bit commands, shifts the data
//   byte out (write) or in (read), and reports the result with a one-cycle
//   cmd_ack pulse.
//   Ports:
//     wb_clk_i : system clock, rising edge
//     arst_i   : asynchronous active-low reset
//     bus      : i2c_byte_sequencer_if.master (host command/status and
//                bit-controller handshake signals)
//   Bit-command encoding: NOP=0000 START=0001 STOP=0010 WRITE=0100 READ=1000.
module i2c_byte_sequencer #(
  parameter int CMD_W = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 arst_i,
  i2c_byte_sequencer_if.master bus
);

  localparam logic [CMD_W-1:0] BC_NOP   = CMD_W'(4'b0000);
  localparam logic [CMD_W-1:0] BC_START = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] BC_STOP  = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] BC_WRITE = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] BC_READ  = CMD_W'(4'b1000);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
  } state_t;

  state_t           state_q,   state_d;
  logic [CMD_W-1:0] bit_cmd_q, bit_cmd_d;
  logic             bit_din_q, bit_din_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             ack_out_q, ack_out_d;
  logic [7:0]       sr_q,      sr_d;
  logic [2:0]       cnt_q,     cnt_d;

  logic go;
  logic abort;

  // A new command is taken only while the previous cmd_ack is low, so a host
  // still holding its command bits during the pulse cannot re-trigger.
  assign go    = bus.ena & (bus.start | bus.stop | bus.read | bus.write) & ~cmd_ack_q;
  assign abort = bus.al | (~bus.ena & (state_q != ST_IDLE));

  always_comb begin
    // NOTE: every signal gets its hold/default value first, so no branch
    // below can leave one unassigned and infer a latch.
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;

    if (abort) begin
      // Silent abort: no cmd_ack, data and ACK status kept for inspection.
      state_d   = ST_IDLE;
      bit_cmd_d = BC_NOP;
      cnt_d     = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            sr_d  = bus.din;
            cnt_d = 3'd7;
            if (bus.start) begin
              state_d = ST_START;  bit_cmd_d = BC_START; bit_din_d = 1'b0;
            end else if (bus.read) begin
              state_d = ST_READ;   bit_cmd_d = BC_READ;  bit_din_d = 1'b1;
            end else if (bus.write) begin
              state_d = ST_WRITE;  bit_cmd_d = BC_WRITE; bit_din_d = bus.din[7];
            end else begin
              state_d = ST_STOP;   bit_cmd_d = BC_STOP;  bit_din_d = 1'b0;
            end
          end
        end
        ST_START: begin
          if (bus.bit_cmd_ack) begin
            if (bus.read) begin
              state_d = ST_READ;   bit_cmd_d = BC_READ;  bit_din_d = 1'b1;
            end else if (bus.write) begin
              state_d = ST_WRITE;  bit_cmd_d = BC_WRITE; bit_din_d = sr_q[7];
            end else if (bus.stop) begin
              state_d = ST_STOP;   bit_cmd_d = BC_STOP;  bit_din_d = 1'b0;
            end else begin
              state_d = ST_IDLE;   bit_cmd_d = BC_NOP;   cmd_ack_d = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (bus.bit_cmd_ack) begin
            sr_d = {sr_q[6:0], 1'b0};
            if (cnt_q == 3'd0) begin
              // Release SDA and read the slave's ACK bit.
              state_d = ST_ACK;    bit_cmd_d = BC_READ;  bit_din_d = 1'b1;
            end else begin
              cnt_d     = cnt_q - 3'd1;
              bit_din_d = sr_q[6];  // MSB after this shift
            end
          end
        end
        ST_READ: begin
          if (bus.bit_cmd_ack) begin
            sr_d = {sr_q[6:0], bus.bit_dout};
            if (cnt_q == 3'd0) begin
              // Drive the host-chosen ACK/NACK back to the slave.
              state_d = ST_ACK;    bit_cmd_d = BC_WRITE; bit_din_d = bus.ack_in;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ST_ACK: begin
          if (bus.bit_cmd_ack) begin
            ack_out_d = bus.bit_dout;
            if (bus.stop) begin
              state_d = ST_STOP;   bit_cmd_d = BC_STOP;  bit_din_d = 1'b0;
            end else begin
              state_d = ST_IDLE;   bit_cmd_d = BC_NOP;   cmd_ack_d = 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bus.bit_cmd_ack) begin
            state_d = ST_IDLE;     bit_cmd_d = BC_NOP;   cmd_ack_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cmd_d = BC_NOP;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments, so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= ST_IDLE;
      bit_cmd_q <= BC_NOP;
      bit_din_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.cmd_ack = cmd_ack_q;
  assign bus.ack_out = ack_out_q;
  assign bus.dout    = sr_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.bit_cmd = bit_cmd_q;
  assign bus.bit_din = bit_din_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer
//   Drives host commands and plays the bit controller. For each command the
//   bench derives the full list of bit commands it must see (START, 8 data
//   bits, ACK bit, STOP) plus the final dout/ack_out, and a negedge monitor
//   compares busy/cmd_ack/bit_cmd/bit_din every cycle and dout/ack_out
//   whenever the sequencer should be idle.
`timescale 1ns/1ps
module tb_i2c_byte_sequencer;

  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  typedef struct packed {
    logic [3:0] cmd;
    logic       din;   // required bit_din
    logic       care;  // bit_din is meaningful for this command
    logic       rsp;   // bit_dout the responder returns with the ack
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_byte_sequencer_if bif ();

  i2c_byte_sequencer dut (
    .wb_clk_i (clk),
    .arst_i   (rst_n),
    .bus      (bif)
  );

  // Reference state: what the outputs must be right now.
  logic       mdl_busy, mdl_cmd_ack, mdl_din, mdl_care, mdl_ack_out;
  logic [3:0] mdl_cmd;
  logic [7:0] mdl_dout;
  logic       chk_en;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(bif.busy),    32'(mdl_busy));
      check("cmd_ack", 32'(bif.cmd_ack), 32'(mdl_cmd_ack));
      check("bit_cmd", 32'(bif.bit_cmd), 32'(mdl_cmd));
      if (mdl_care) check("bit_din", 32'(bif.bit_din), 32'(mdl_din));
      if (!mdl_busy) begin
        check("dout",    32'(bif.dout),    32'(mdl_dout));
        check("ack_out", 32'(bif.ack_out), 32'(mdl_ack_out));
      end
    end
  end

  task automatic clear_cmd();
    bif.start = 1'b0; bif.stop = 1'b0; bif.read = 1'b0; bif.write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Runs one command; called and returns 1ns after a rising edge.
  // abort_at > 0: abort (al, or ena=0 when by_ena) right after that many acks.
  task automatic run_cmd(input bit st, input bit sp, input bit rd, input bit wr,
                         input bit ai, input logic [7:0] d, input logic [7:0] rdata,
                         input bit sack, input int abort_at, input bit by_ena,
                         output logic [7:0] obs_wr, output int n_bits);
    item_t      exp[$];
    logic [7:0] nxt_dout;
    logic       nxt_ack;
    int         k, wait_c, budget;
    bit         done;

    exp = {};
    if (st) exp.push_back('{cmd: C_START, din: 1'b0, care: 1'b0, rsp: 1'($urandom)});
    if (rd) begin
      for (int i = 7; i >= 0; i--)
        exp.push_back('{cmd: C_READ, din: 1'b1, care: 1'b1, rsp: rdata[i]});
      exp.push_back('{cmd: C_WRITE, din: ai, care: 1'b1, rsp: sack});
    end else if (wr) begin
      for (int i = 7; i >= 0; i--)
        exp.push_back('{cmd: C_WRITE, din: d[i], care: 1'b1, rsp: 1'($urandom)});
      exp.push_back('{cmd: C_READ, din: 1'b1, care: 1'b1, rsp: sack});
    end
    if (sp) exp.push_back('{cmd: C_STOP, din: 1'b0, care: 1'b0, rsp: 1'($urandom)});

    // Read fills the shift register with slave data; write shifts all of
    // din out leaving zeros; START/STOP alone leave din untouched.
    nxt_dout = rd ? rdata : (wr ? 8'h00 : d);
    nxt_ack  = (rd | wr) ? sack : mdl_ack_out;

    bif.start = st; bif.stop = sp; bif.read = rd; bif.write = wr;
    bif.ack_in = ai; bif.din = d;
    obs_wr = 8'h00;
    n_bits = 0;

    @(posedge clk); #1;
    mdl_busy = 1'b1;
    mdl_cmd  = exp[0].cmd; mdl_din = exp[0].din; mdl_care = exp[0].care;
    k = 0; wait_c = $urandom_range(0, 3); budget = 0; done = 1'b0;

    while (!done && budget < 200) begin
      if (wait_c == 0) begin
        bif.bit_cmd_ack = 1'b1;
        bif.bit_dout    = exp[k].rsp;
        if (bif.bit_cmd == C_WRITE) obs_wr = {obs_wr[6:0], bif.bit_din};
      end else begin
        wait_c--;
      end
      @(posedge clk); #1;
      budget++;
      if (bif.bit_cmd_ack) begin
        bif.bit_cmd_ack = 1'b0;
        n_bits++;
        k++;
        if (n_bits == abort_at) begin
          mdl_cmd = exp[k].cmd; mdl_din = exp[k].din; mdl_care = exp[k].care;
          clear_cmd();
          if (by_ena) bif.ena = 1'b0; else bif.al = 1'b1;
          @(posedge clk); #1;
          bif.al = 1'b0; bif.ena = 1'b1;
          mdl_busy = 1'b0; mdl_cmd = C_NOP; mdl_care = 1'b0;
          mdl_dout = 8'(d << (n_bits - int'(st)));
          done = 1'b1;
        end else if (k == exp.size()) begin
          mdl_busy = 1'b0; mdl_cmd = C_NOP; mdl_care = 1'b0; mdl_cmd_ack = 1'b1;
          mdl_dout = nxt_dout; mdl_ack_out = nxt_ack;
          clear_cmd();
          @(posedge clk); #1;
          mdl_cmd_ack = 1'b0;
          done = 1'b1;
        end else begin
          mdl_cmd = exp[k].cmd; mdl_din = exp[k].din; mdl_care = exp[k].care;
          wait_c = $urandom_range(0, 3);
        end
      end
    end
    check("cmd_done", 32'(done), 32'd1);
  endtask

  logic [7:0] obs;
  int         nb;

  initial begin
    bif.ena = 1'b0; bif.ack_in = 1'b0; bif.din = 8'h00;
    bif.bit_cmd_ack = 1'b0; bif.bit_dout = 1'b0; bif.al = 1'b0;
    clear_cmd();
    chk_en = 1'b0;
    mdl_busy = 1'b0; mdl_cmd_ack = 1'b0; mdl_cmd = C_NOP; mdl_din = 1'b0;
    mdl_care = 1'b0; mdl_dout = 8'h00; mdl_ack_out = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_bit_cmd", 32'(bif.bit_cmd), 32'(C_NOP));
    check("rst_busy",    32'(bif.busy),    32'd0);
    check("rst_dout",    32'(bif.dout),    32'h00);
    check("rst_cmd_ack", 32'(bif.cmd_ack), 32'd0);
    check("rst_bit_din", 32'(bif.bit_din), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1; bif.ena = 1'b1;
    idle(2);

    // Write 0xA5 with START, slave ACKs.
    run_cmd(1, 0, 0, 1, 0, 8'hA5, 8'h00, 0, -1, 0, obs, nb);
    check("a5_bits",    32'(obs),         32'hA5);
    check("a5_nbits",   32'(nb),          32'd10);
    check("a5_ack_out", 32'(bif.ack_out), 32'd0);
    idle(2);

    // Read with NACK and STOP.
    run_cmd(0, 1, 1, 0, 1, 8'h00, 8'h69, 1, -1, 0, obs, nb);
    check("rd_dout",   32'(bif.dout), 32'h69);
    check("rd_ackbit", 32'(obs[0]),   32'd1);
    check("rd_nbits",  32'(nb),       32'd10);
    idle(1);

    // Write 0x00, slave NACKs, no STOP.
    run_cmd(0, 0, 0, 1, 0, 8'h00, 8'h00, 1, -1, 0, obs, nb);
    check("nack_ack_out", 32'(bif.ack_out), 32'd1);
    check("nack_nbits",   32'(nb),          32'd9);
    idle(1);

    // STOP only.
    run_cmd(0, 1, 0, 0, 0, 8'h3C, 8'h00, 0, -1, 0, obs, nb);
    check("stop_nbits", 32'(nb),       32'd1);
    check("stop_dout",  32'(bif.dout), 32'h3C);
    idle(1);

    // Arbitration loss after the 3rd write bit, then a normal write.
    run_cmd(1, 0, 0, 1, 0, 8'hC3, 8'h00, 0, 4, 0, obs, nb);
    check("al_dout", 32'(bif.dout), 32'h18);
    idle(2);
    run_cmd(1, 0, 0, 1, 0, 8'h5A, 8'h00, 0, -1, 0, obs, nb);
    check("post_al_bits", 32'(obs), 32'h5A);
    idle(1);

    // Core disabled mid-write.
    run_cmd(0, 1, 0, 1, 0, 8'hF0, 8'h00, 0, 2, 1, obs, nb);
    check("ena_dout", 32'(bif.dout), 32'hC0);
    idle(1);

    // Commands ignored while disabled.
    bif.ena = 1'b0; bif.write = 1'b1; bif.din = 8'hFF;
    idle(4);
    bif.write = 1'b0; bif.ena = 1'b1;
    idle(1);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      bit st, sp, rd, wr;
      st = 1'($urandom); sp = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      if (!(st | sp | rd | wr)) sp = 1'b1;
      run_cmd(st, sp, rd, wr, 1'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), -1, 0, obs, nb);
      idle($urandom_range(0, 2));
    end

    // Reset asserted during the 4th bit of a read.
    chk_en = 1'b0;
    bif.read = 1'b1; bif.din = 8'h00;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bif.bit_cmd_ack = 1'b1; bif.bit_dout = 1'b1;
      @(posedge clk); #1;
      bif.bit_cmd_ack = 1'b0;
    end
    check("rmr_pre_cmd", 32'(bif.bit_cmd), 32'(C_READ));
    #2 rst_n = 1'b0;
    #1;
    check("rmr_bit_cmd", 32'(bif.bit_cmd), 32'(C_NOP));
    check("rmr_busy",    32'(bif.busy),    32'd0);
    check("rmr_dout",    32'(bif.dout),    32'h00);
    check("rmr_cmd_ack", 32'(bif.cmd_ack), 32'd0);
    bif.read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_busy = 1'b0; mdl_cmd_ack = 1'b0; mdl_cmd = C_NOP; mdl_care = 1'b0;
    mdl_dout = 8'h00; mdl_ack_out = 1'b0;
    chk_en = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
